regfile_wb_scheduler: RTL and testbench

// - Shares the single write port of the 32x32 register file between NUM_REQ write-back sources (ALU, load, mul/CSR).
// - Round-robin arbitration with valid/ready handshake; registered output drives register write_reg/rd_addr/write_data.
// - Holds a pending-write scoreboard so decode can stall on RAW/WAW hazards until the producer's write commits.

---
 rtl/regfile_ctrl_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/regfile_wb_scheduler.sv | 86 ++++++++
 tb/tb_regfile_wb_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file write-back controller.
package regfile_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_SIZE  = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t             rd;
    logic [DATA_SIZE-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr;
  logic             found;
  int               t;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    t         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      t = int'(ptr) + i;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      if (!found && req[t]) begin
        grant[t]  = 1'b1;
        grant_idx = PTR_W'(t);
        found     = 1'b1;
      end
    end
  end

  // The winner drops to lowest priority only when its transfer actually happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port among write-back sources and tracks
// pending destinations so decode can stall on RAW/WAW hazards.
module regfile_wb_scheduler
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_SIZE   = 32,
  parameter int NUM_REQ     = 3,
  parameter int STP_REGSIZE = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0]   req_rd_addr,
  input  logic [NUM_REQ*DATA_SIZE-1:0]    req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            issue_valid,
  input  logic [REG_ADDR_W-1:0]           issue_rd,
  input  logic [REG_ADDR_W-1:0]           rs1_addr,
  input  logic [REG_ADDR_W-1:0]           rs2_addr,
  output logic                            stall,
  output logic                            write_reg,
  output logic [REG_ADDR_W-1:0]           rd_addr,
  output logic [DATA_SIZE-1:0]            write_data
);

  logic [NUM_REQ-1:0]         grant;
  logic [$clog2(NUM_REQ)-1:0] grant_idx;
  logic                       accept;
  wb_req_t                    sel;
  logic [STP_REGSIZE-1:0]     pending;
  logic [STP_REGSIZE-1:0]     pending_next;
  logic                       hazard;
  logic                       issue_set;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = rst ? '0 : grant;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    sel.rd   = req_rd_addr[grant_idx*REG_ADDR_W +: REG_ADDR_W];
    sel.data = req_data[grant_idx*DATA_SIZE +: DATA_SIZE];
  end

  // Output stage: x0 write-backs are consumed but never raise the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_reg  <= 1'b0;
      rd_addr    <= '0;
      write_data <= '0;
    end else if (accept) begin
      write_reg  <= (sel.rd != '0);
      rd_addr    <= sel.rd;
      write_data <= sel.data;
    end else begin
      write_reg  <= 1'b0;
    end
  end

  // No bypass: a register committing at this edge still reads as busy.
  assign hazard = (pending[rs1_addr] && (rs1_addr != '0)) ||
                  (pending[rs2_addr] && (rs2_addr != '0)) ||
                  (issue_valid && pending[issue_rd] && (issue_rd != '0));
  assign stall     = ~rst & hazard;
  assign issue_set = issue_valid & ~stall & (issue_rd != '0);

  // Set is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    pending_next = pending;
    if (write_reg) pending_next[rd_addr] = 1'b0;
    if (issue_set) pending_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed plus randomized bench for regfile_wb_scheduler with a behavioural model.
module tb_regfile_wb_scheduler;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*5-1:0]  req_rd_addr;
  logic [N*32-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            stall;
  logic            write_reg;
  logic [4:0]      rd_addr;
  logic [31:0]     write_data;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          m_ptr;
  bit          m_pend [32];
  bit          m_wr;
  int          m_rd;
  logic [31:0] m_data;
  logic [N-1:0] acc_mask;

  regfile_wb_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_rd_addr (req_rd_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .stall       (stall),
    .write_reg   (write_reg),
    .rd_addr     (rd_addr),
    .write_data  (write_data)
  );

  always #5 clk = ~clk;

  function automatic int exp_grant();
    int j;
    if (rst) return -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit busy(input logic [4:0] r);
    return (r != 5'd0) && m_pend[r];
  endfunction

  function automatic bit exp_stall();
    if (rst) return 1'b0;
    return busy(rs1_addr) || busy(rs2_addr) || (issue_valid && busy(issue_rd));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int           g;
    bit           s;
    logic [N-1:0] er;
    #1;
    g  = exp_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    s  = exp_stall();
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("stall", 32'(stall), 32'(s));
    acc_mask = req_valid & er;
    @(posedge clk);
    #1;
    if (rst) begin
      m_wr = 0; m_rd = 0; m_data = '0; m_ptr = 0;
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
    end else begin
      if (m_wr) m_pend[m_rd] = 0;
      if (issue_valid && !s && issue_rd != 5'd0) m_pend[issue_rd] = 1;
      if (g >= 0) begin
        m_rd   = int'(req_rd_addr[g*5 +: 5]);
        m_data = req_data[g*32 +: 32];
        m_wr   = (m_rd != 0);
        m_ptr  = (g + 1) % N;
      end else begin
        m_wr = 0;
      end
    end
    chk("write_reg", 32'(write_reg), 32'(m_wr));
    chk("rd_addr", 32'(rd_addr), 32'(m_rd));
    chk("write_data", write_data, m_data);
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    req_valid[i]          = v;
    req_rd_addr[i*5 +: 5] = rd;
    req_data[i*32 +: 32]  = d;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_rd_addr = '0; req_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
    m_ptr = 0; m_wr = 0; m_rd = 0; m_data = '0; acc_mask = '0;
    for (int r = 0; r < 32; r++) m_pend[r] = 0;

    // Reset held with every requester valid
    set_req(0, 1'b1, 5'd1, 32'hA0);
    set_req(1, 1'b1, 5'd2, 32'hA1);
    set_req(2, 1'b1, 5'd3, 32'hA2);
    step(); step();

    // Round robin across all three
    rst = 1'b0;
    repeat (6) step();

    // Single source
    req_valid = '0;
    set_req(2, 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    req_valid = '0;
    step();

    // x0 write-back
    set_req(0, 1'b1, 5'd0, 32'h1234);
    step();
    req_valid = '0;
    step();

    // RAW hazard on x7
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0; rs1_addr = 5'd7;
    set_req(0, 1'b1, 5'd7, 32'h77);
    step();
    req_valid = '0;
    step();
    step();
    rs1_addr = 5'd0;

    // Same-cycle commit and issue of x9
    set_req(1, 1'b1, 5'd9, 32'h99);
    step();
    req_valid = '0; issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    issue_valid = 1'b0; rs2_addr = 5'd9;
    step();
    rs2_addr = 5'd0;

    // Reset in the middle of a transfer
    set_req(0, 1'b1, 5'd4, 32'h44);
    issue_valid = 1'b1; issue_rd = 5'd10;
    step();
    rst = 1'b1; issue_valid = 1'b0; rs1_addr = 5'd10;
    step();
    rst = 1'b0; req_valid = '0;
    step();
    rs1_addr = 5'd0;

    // Randomized traffic; a valid request holds its payload until accepted
    req_valid = '0;
    acc_mask  = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || acc_mask[i])
          set_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      rs1_addr    = 5'($urandom_range(0, 7));
      rs2_addr    = 5'($urandom_range(0, 7));
      rst         = ($urandom_range(0, 49) == 0);
      step();
      if (rst) req_valid = '0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
